// File: rtl/bp_common_pkg.sv
// Shared types for the BlackParrot cache-side blocks.
// Holds the state encoding of the I$/D$ miss-channel arbiter.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_arb_idle,
    e_arb_meta,
    e_arb_busy
  } bp_cache_arb_state_e;

endpackage

// File: rtl/bp_cache_req_arbiter.sv
// Shares one LCE miss channel between the I$ (port 0) and the D$ (port 1).
// Round-robin grant, one miss in flight, completion routed back to the owner.
module bp_cache_req_arbiter
  import bp_common_pkg::*;
#(
  parameter int req_width_p  = 64,
  parameter int meta_width_p = 8,
  parameter int timeout_p    = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [2*req_width_p-1:0]  req_i,
  input  logic [1:0]                req_v_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*meta_width_p-1:0] req_metadata_i,
  input  logic [1:0]                req_metadata_v_i,
  output logic [1:0]                req_complete_o,
  output logic [req_width_p-1:0]    lce_req_o,
  output logic                      lce_req_v_o,
  input  logic                      lce_req_ready_i,
  output logic [meta_width_p-1:0]   lce_metadata_o,
  output logic                      lce_metadata_v_o,
  input  logic                      lce_complete_i,
  output logic                      busy_o,
  output logic                      timeout_o,
  output logic                      protocol_err_o
);

  localparam int wdog_w_lp = $clog2(timeout_p + 1);
  localparam logic [wdog_w_lp-1:0] wdog_max_lp  = wdog_w_lp'(timeout_p);
  localparam logic [wdog_w_lp-1:0] wdog_last_lp = wdog_w_lp'(timeout_p - 1);

  bp_cache_arb_state_e state_r, state_n;
  logic                 owner_r;
  logic                 rr_last_r;
  logic [wdog_w_lp-1:0] wdog_r;
  logic                 timeout_r;
  logic                 err_r;

  logic sel;
  logic accept;
  logic err_set;

  // With both valid, the requester not granted last time wins.
  assign sel = req_v_i[1] & (~req_v_i[0] | ~rr_last_r);

  always_comb begin
    state_n          = state_r;
    accept           = 1'b0;
    err_set          = 1'b0;
    req_ready_o      = 2'b00;
    req_complete_o   = 2'b00;
    lce_req_o        = sel ? req_i[2*req_width_p-1:req_width_p] : req_i[req_width_p-1:0];
    lce_req_v_o      = 1'b0;
    lce_metadata_o   = owner_r ? req_metadata_i[2*meta_width_p-1:meta_width_p]
                               : req_metadata_i[meta_width_p-1:0];
    lce_metadata_v_o = 1'b0;

    unique case (state_r)
      e_arb_idle: begin
        lce_req_v_o      = |req_v_i;
        req_ready_o[sel] = lce_req_ready_i & (|req_v_i);
        accept           = (|req_v_i) & lce_req_ready_i;
        if (accept)
          state_n = e_arb_meta;
        if (lce_complete_i || (|req_metadata_v_i))
          err_set = 1'b1;
      end
      e_arb_meta: begin
        // An early completion pre-empts the metadata beat.
        lce_metadata_v_o = req_metadata_v_i[owner_r] & ~lce_complete_i;
        if (lce_complete_i) begin
          req_complete_o[owner_r] = 1'b1;
          state_n                 = e_arb_idle;
          err_set                 = 1'b1;
        end else if (req_metadata_v_i[owner_r]) begin
          state_n = e_arb_busy;
        end
        if (req_metadata_v_i[~owner_r])
          err_set = 1'b1;
      end
      e_arb_busy: begin
        if (lce_complete_i) begin
          req_complete_o[owner_r] = 1'b1;
          state_n                 = e_arb_idle;
        end
        if (req_metadata_v_i[~owner_r])
          err_set = 1'b1;
      end
      default: state_n = e_arb_idle;
    endcase

    // Async reset must silence the combinational paths immediately, not just the registers.
    if (reset_i) begin
      req_ready_o      = 2'b00;
      req_complete_o   = 2'b00;
      lce_req_o        = '0;
      lce_req_v_o      = 1'b0;
      lce_metadata_o   = '0;
      lce_metadata_v_o = 1'b0;
      accept           = 1'b0;
      err_set          = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= e_arb_idle;
      owner_r   <= 1'b0;
      rr_last_r <= 1'b1;
      wdog_r    <= '0;
      timeout_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        owner_r   <= sel;
        rr_last_r <= sel;
        wdog_r    <= '0;
      end else if (state_r != e_arb_idle && wdog_r != wdog_max_lp) begin
        wdog_r <= wdog_r + 1'b1;
      end
      // Flag on the cycle the count reaches the limit.
      if (state_r != e_arb_idle && wdog_r == wdog_last_lp)
        timeout_r <= 1'b1;
      if (err_set)
        err_r <= 1'b1;
    end
  end

  assign busy_o         = (state_r != e_arb_idle);
  assign timeout_o      = timeout_r;
  assign protocol_err_o = err_r;

endmodule
